// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the pushbutton / DIP-switch input conditioner.
// Button FSM encoding, default timing constants and the counter-width helper.
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int REPEAT_DELAY_DEF    = 25000000;
   localparam int REPEAT_PERIOD_DEF   = 5000000;

   // Bits needed for a counter that runs 0 .. n-1 (never less than one bit)
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input: 2-flop synchronizer, saturating stability counter and stable level register.
// Level follows raw DEBOUNCE_CYCLES+2 cycles after a clean edge; rise/fall pulse with the level change; no backpressure.
module debounce_cell
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic synced,
   output logic done,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic [CW-1:0] cnt;

   // The change is accepted on the edge that ends the last differing sample
   assign done = (synced != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         synced <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta   <= raw;
         synced <= meta;
         rise   <= done && synced;
         fall   <= done && !synced;
         if (done) begin
            level <= synced;
            cnt   <= '0;
         end else if (synced != level) begin
            if (cnt != CNT_LAST)
               cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Debounced pushbutton levels with press/release pulses, debounced DIP switches with a change pulse.
// Latency raw edge -> level/pulse is DEBOUNCE_CYCLES+2; no backpressure. Auto-repeat: INPUT_CONDITIONER_AUTOREPEAT_EN.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int N_SW            = 8,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_SW-1:0]  sw_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_SW-1:0]  sw_level,
   output logic             sw_change
);

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   localparam int            REP_MAX         = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW              = cnt_width(REP_MAX);
   localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`else
   localparam bit UNUSED_REPEAT_CFG = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
`endif

   logic [N_BTN-1:0] btn_cell_unused;
   logic [N_SW-1:0]  sw_synced_unused;
   logic [N_SW-1:0]  sw_done_unused;
   logic [N_SW-1:0]  sw_rise;
   logic [N_SW-1:0]  sw_fall;
   logic             unused_ok;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic       synced, done, cell_level, cell_rise, cell_fall;
      logic       level_o, press_d, release_d, rep_fire;
      logic       press_q, release_q;
      btn_state_t state_q, state_d;

      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk    (clk),
         .rst    (rst),
         .raw    (btn_raw[i]),
         .synced (synced),
         .done   (done),
         .level  (cell_level),
         .rise   (cell_rise),
         .fall   (cell_fall)
      );

      always_ff @(posedge clk) begin
         if (rst) state_q <= IDLE;
         else     state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:         if (synced) state_d = PRESS_WAIT;
            PRESS_WAIT:   if (done) state_d = HELD;
                          else if (!synced) state_d = IDLE;
            HELD:         if (!synced) state_d = RELEASE_WAIT;
            RELEASE_WAIT: if (done) state_d = IDLE;
                          else if (synced) state_d = HELD;
            default:      state_d = IDLE;
         endcase
      end

      always_comb begin
         level_o   = (state_q == HELD) || (state_q == RELEASE_WAIT);
         press_d   = ((state_q == PRESS_WAIT) && done) || rep_fire;
         release_d = (state_q == RELEASE_WAIT) && done;
      end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      logic [RW-1:0] rep_cnt;
      logic          rep_first;

      assign rep_fire = (state_q == HELD) &&
                        (rep_cnt == (rep_first ? REP_PERIOD_LAST : REP_DELAY_LAST));

      // Counts HELD cycles only; RELEASE_WAIT holds the value so a bounce back resumes it
      always_ff @(posedge clk) begin
         if (rst || state_q == IDLE || state_q == PRESS_WAIT) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
         end else if (state_q == HELD && rep_cnt != '1) begin
            rep_cnt   <= rep_cnt + 1'b1;
         end
      end
`else
      assign rep_fire = 1'b0;
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      assign btn_level[i]       = level_o;
      assign btn_press[i]       = press_q;
      assign btn_release[i]     = release_q;
      assign btn_cell_unused[i] = cell_level ^ cell_rise ^ cell_fall;
   end

   for (genvar j = 0; j < N_SW; j++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk    (clk),
         .rst    (rst),
         .raw    (sw_raw[j]),
         .synced (sw_synced_unused[j]),
         .done   (sw_done_unused[j]),
         .level  (sw_level[j]),
         .rise   (sw_rise[j]),
         .fall   (sw_fall[j])
      );
   end

   // rise/fall are already one cycle behind the level decision, so this lands after the update
   always_ff @(posedge clk) begin
      if (rst) sw_change <= 1'b0;
      else     sw_change <= |(sw_rise | sw_fall);
   end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   assign unused_ok = ^{btn_cell_unused, sw_synced_unused, sw_done_unused};
`else
   assign unused_ok = ^{btn_cell_unused, sw_synced_unused, sw_done_unused, UNUSED_REPEAT_CFG};
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_input_conditioner;

   localparam int NB = 4;
   localparam int NS = 8;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif
   localparam logic [3:0] P0 = REP ? 4'b0001 : 4'b0000;
   localparam logic [3:0] P9 = REP ? 4'b1001 : 4'b0000;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic [NS-1:0] sw_raw;
   logic [NB-1:0] btn_level, btn_press, btn_release;
   logic [NS-1:0] sw_level;
   logic          sw_change;

   always #5 clk = ~clk;

   input_conditioner #(
      .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .sw_raw      (sw_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .sw_level    (sw_level),
      .sw_change   (sw_change)
   );

   typedef struct {
      int         cyc;
      logic [3:0] btn;
      logic [7:0] sw;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [7:0] swl;
      logic       swc;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(input int c, input logic [3:0] b, input logic [7:0] s,
                               input logic [3:0] l, input logic [3:0] p, input logic [3:0] r,
                               input logic [7:0] sl, input logic sc);
      vec_t v;
      v.cyc = c; v.btn = b; v.sw = s; v.lvl = l; v.prs = p; v.rel = r; v.swl = sl; v.swc = sc;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output bundle: {btn_level, btn_press, btn_release, sw_level, sw_change}
   task automatic check(input string name, input logic [3:0] l, input logic [3:0] p,
                        input logic [3:0] r, input logic [7:0] sl, input logic sc);
      logic [20:0] act, exp;
      act = {btn_level, btn_press, btn_release, sw_level, sw_change};
      exp = {l, p, r, sl, sc};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got lvl=%b prs=%b rel=%b swl=%h swc=%b, want lvl=%b prs=%b rel=%b swl=%h swc=%b",
                  name, btn_level, btn_press, btn_release, sw_level, sw_change, l, p, r, sl, sc);
      end
   endtask

   initial begin
      vec_t cur;
      int   idx;

      //          cyc  btn      sw     lvl      prs      rel      swl    swc
      tbl.push_back(mk(  0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 10, 4'b0001, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 16, 4'b0001, 8'h00, 4'b0001, 4'b0001, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 17, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 20, 4'b0011, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 23, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 26, 4'b0011, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 29, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 30, 4'b0011, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 33, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 34, 4'b0011, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 36, 4'b0011, 8'h00, 4'b0001, P0,      4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 37, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 40, 4'b0101, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 44, 4'b0101, 8'h00, 4'b0001, P0,      4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 45, 4'b0101, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 46, 4'b0101, 8'h00, 4'b0101, 4'b0100, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 47, 4'b0101, 8'h00, 4'b0101, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 50, 4'b0001, 8'h00, 4'b0101, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 52, 4'b0001, 8'h00, 4'b0101, P0,      4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 53, 4'b0001, 8'h00, 4'b0101, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 56, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0100, 8'h00, 1'b0));
      tbl.push_back(mk( 57, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 60, 4'b0000, 8'h00, 4'b0001, P0,      4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 61, 4'b0000, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 66, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0001, 8'h00, 1'b0));
      tbl.push_back(mk( 67, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 70, 4'b1001, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 76, 4'b1001, 8'h00, 4'b1001, 4'b1001, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 77, 4'b1001, 8'h00, 4'b1001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 96, 4'b1001, 8'h00, 4'b1001, P9,      4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 97, 4'b1001, 8'h00, 4'b1001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk( 98, 4'b0000, 8'h00, 4'b1001, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk(104, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1001, 8'h00, 1'b0));
      tbl.push_back(mk(105, 4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk(110, 4'b0000, 8'hA5, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0));
      tbl.push_back(mk(116, 4'b0000, 8'hA5, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b0));
      tbl.push_back(mk(117, 4'b0000, 8'hA5, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b1));
      tbl.push_back(mk(118, 4'b0000, 8'hA5, 4'b0000, 4'b0000, 4'b0000, 8'hA5, 1'b0));

      rst = 1'b1;
      btn_raw = '0;
      sw_raw = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Each entry holds its inputs and expected outputs until the next entry's cycle
      idx = 0;
      cur = tbl[0];
      for (int c = 0; c <= 125; c++) begin
         if (c > 0) tick();
         if (idx < tbl.size() && tbl[idx].cyc == c) begin
            cur = tbl[idx];
            idx++;
         end
         btn_raw = cur.btn;
         sw_raw  = cur.sw;
         check($sformatf("tbl_c%0d", c), cur.lvl, cur.prs, cur.rel, cur.swl, cur.swc);
      end

      // Reset for 2 cycles while btn0 sits in PRESS_WAIT with count 2
      btn_raw = 4'b0001;
      for (int k = 1; k <= 13; k++) begin
         tick();
         check($sformatf("rst_mid_k%0d", k),
               (k >= 12) ? 4'b0001 : 4'b0000,
               (k == 12) ? 4'b0001 : 4'b0000,
               4'b0000,
               (k >= 5 && k < 12) ? 8'h00 : 8'hA5,
               (k == 13));
         if (k == 4) rst = 1'b1;
         if (k == 6) rst = 1'b0;
      end

      // Two-cycle release glitch: RELEASE_WAIT bounces back to HELD with no pulses
      btn_raw = 4'b0000;
      for (int k = 1; k <= 12; k++) begin
         tick();
         check($sformatf("rel_glitch_k%0d", k), 4'b0001, 4'b0000, 4'b0000, 8'hA5, 1'b0);
         if (k == 2) btn_raw = 4'b0001;
      end

      btn_raw = 4'b0000;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("release_k%0d", k),
               (k < 6) ? 4'b0001 : 4'b0000,
               4'b0000,
               (k == 6) ? 4'b0001 : 4'b0000,
               8'hA5, 1'b0);
      end

      // Long hold: one press at acceptance, repeats at +20,+28,+36,+44 only when enabled
      tick();
      tick();
      btn_raw = 4'b0100;
      for (int k = 1; k <= 56; k++) begin
         tick();
         check($sformatf("hold_k%0d", k),
               (k >= 6) ? 4'b0100 : 4'b0000,
               ((k == 6) || (REP && k >= 26 && ((k - 26) % 8) == 0)) ? 4'b0100 : 4'b0000,
               4'b0000, 8'hA5, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
